div_iter: RTL and testbench



---
 rtl/div_iter_pkg.sv | 24 ++
 rtl/div_iter_if.sv | 34 +++
 rtl/div_iter_sign_fix.sv | 13 +
 rtl/div_iter.sv | 170 +++++++++++++++++
 tb/tb_div_iter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/div_iter_pkg.sv
// Shared constants for the iterative divider: FSM state encoding,
// handshake levels and a sizing helper for the iteration counter.
package div_iter_pkg;

  // Divider FSM states, 2-bit encoded.
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  // Handshake levels as seen by the EX stage.
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  // Counter must be able to hold the value WIDTH itself, not just WIDTH-1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_iter_if.sv
// EX-stage divide handshake bundle: EX is the master, the divider responds.
interface div_iter_if #(
  parameter int WIDTH = 32
);

  logic                 signed_div_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 start_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;

  modport master (
    output signed_div_i,
    output opdata1_i,
    output opdata2_i,
    output start_i,
    output annul_i,
    input  result_o,
    input  ready_o
  );

  modport slave (
    input  signed_div_i,
    input  opdata1_i,
    input  opdata2_i,
    input  start_i,
    input  annul_i,
    output result_o,
    output ready_o
  );

endinterface

// File: rtl/div_iter_sign_fix.sv
// Conditional two's-complement negate. Shared by operand magnitude
// extraction and by the quotient/remainder sign fixup.
module div_iter_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             negate_i,
  output logic [WIDTH-1:0] value_o
);

  assign value_o = negate_i ? (~value_i + {{(WIDTH-1){1'b0}}, 1'b1}) : value_i;

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider answering the EX-stage divide
// handshake. Produces {remainder, quotient} after WIDTH iterations,
// handles DIV and DIVU, and short-circuits division by zero.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  div_iter_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  div_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  // Upper half holds the partial remainder, lower half starts as the
  // dividend magnitude and fills up with quotient bits from the right.
  logic [2*WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]     divisor_q, divisor_d;
  // Sign bits are only ever set for signed requests, so an unsigned
  // divide naturally skips the fixup.
  logic                 sign1_q, sign1_d;
  logic                 sign2_q, sign2_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;

  logic [WIDTH-1:0]     op1_abs;
  logic [WIDTH-1:0]     op2_abs;
  logic [WIDTH-1:0]     quot_fixed;
  logic [WIDTH-1:0]     rem_fixed;
  logic [WIDTH:0]       shifted_top;
  logic [WIDTH:0]       trial;
  logic [WIDTH-1:0]     next_rem;
  logic [WIDTH-1:0]     next_low;

  // Operand magnitudes, taken straight from the bus on the start cycle.
  div_iter_sign_fix #(.WIDTH(WIDTH)) u_abs_op1 (
    .value_i  (bus.opdata1_i),
    .negate_i (bus.signed_div_i & bus.opdata1_i[WIDTH-1]),
    .value_o  (op1_abs)
  );

  div_iter_sign_fix #(.WIDTH(WIDTH)) u_abs_op2 (
    .value_i  (bus.opdata2_i),
    .negate_i (bus.signed_div_i & bus.opdata2_i[WIDTH-1]),
    .value_o  (op2_abs)
  );

  // Truncating division: quotient negative when signs differ, remainder
  // follows the dividend. The most-negative / -1 case wraps to itself.
  div_iter_sign_fix #(.WIDTH(WIDTH)) u_fix_quot (
    .value_i  (work_q[WIDTH-1:0]),
    .negate_i (sign1_q ^ sign2_q),
    .value_o  (quot_fixed)
  );

  div_iter_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
    .value_i  (work_q[2*WIDTH-1:WIDTH]),
    .negate_i (sign1_q),
    .value_o  (rem_fixed)
  );

  // One restoring step: shift left by one, trial-subtract the divisor on
  // WIDTH+1 bits, keep the difference only if it did not go negative.
  assign shifted_top = work_q[2*WIDTH-1:WIDTH-1];
  assign trial       = shifted_top - {1'b0, divisor_q};
  assign next_rem    = trial[WIDTH] ? shifted_top[WIDTH-1:0] : trial[WIDTH-1:0];
  assign next_low    = {work_q[WIDTH-2:0], ~trial[WIDTH]};

  // Next-state logic for the control FSM and the datapath registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    sign1_d   = sign1_q;
    sign2_d   = sign2_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      DivFree: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
        if (bus.start_i == DivStart && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            state_d   = DivOn;
            cnt_d     = '0;
            work_d    = {{WIDTH{1'b0}}, op1_abs};
            divisor_d = op2_abs;
            sign1_d   = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
            sign2_d   = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
          end
        end
      end

      DivByZero: begin
        if (bus.annul_i) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end else begin
          state_d  = DivEnd;
          result_d = '0;
          ready_d  = DivResultReady;
        end
      end

      DivOn: begin
        if (bus.annul_i) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end else if (cnt_q == CNT_W'(WIDTH)) begin
          state_d  = DivEnd;
          result_d = {rem_fixed, quot_fixed};
          ready_d  = DivResultReady;
        end else begin
          work_d = {next_rem, next_low};
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end

      DivEnd: begin
        if (bus.annul_i || bus.start_i == DivStop) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end
      end

      default: begin
        state_d  = DivFree;
        result_d = '0;
        ready_d  = DivResultNotReady;
      end
    endcase
  end

  // All state, including the registered outputs, clears immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      sign1_q   <= sign1_d;
      sign2_q   <= sign2_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter. The driver issues divides and pushes
// the reference answer into a scoreboard queue; a separate monitor pops
// and compares each time ready_o rises.
module tb_div_iter;

  localparam int W = 32;

  logic clk;
  logic rst;

  div_iter_if #(.WIDTH(W)) bus ();

  div_iter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [2*W-1:0] sb_q[$];
  int             check_count;
  int             pass_count;
  logic           ready_prev;

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain integer arithmetic on 64-bit values, so the
  // most-negative / -1 case cannot trap and simply wraps when truncated.
  function automatic logic [2*W-1:0] model(input logic sgn, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == '0) return '0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  // Single comparison point used by both driver and monitor.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Count edges until ready_o is seen, optionally scrambling the operand
  // inputs after the start edge to show the latched copies are used.
  task automatic waitReady(input bit scramble, output int edges, output bit seen);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (scramble) begin
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = 1'($urandom);
      end
      if (bus.ready_o === 1'b1) seen = 1'b1;
    end
  endtask

  // Full handshake: start, wait for ready, hold start for a while, release.
  task automatic applyStimulus(input logic sgn, input logic [W-1:0] a,
                               input logic [W-1:0] b, input int hold);
    logic [2*W-1:0] expected;
    int             edges;
    bit             seen;
    expected = model(sgn, a, b);
    sb_q.push_back(expected);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    waitReady(1'b1, edges, seen);
    checkOutput("latency", 64'(edges), (b == '0) ? 64'd2 : 64'(W + 2));
    if (!seen && sb_q.size() > 0) void'(sb_q.pop_back());
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("hold_ready", 64'(bus.ready_o), 64'd1);
      checkOutput("hold_result", bus.result_o, expected);
    end
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("release_ready", 64'(bus.ready_o), 64'd0);
    checkOutput("release_result", bus.result_o, 64'd0);
  endtask

  // Monitor: every rising ready_o must match the oldest expected result.
  initial begin
    logic [2*W-1:0] expected;
    ready_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ready_o === 1'b1 && !ready_prev) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_ready", 64'd1, 64'd0);
        end else begin
          expected = sb_q.pop_front();
          checkOutput("result", bus.result_o, expected);
        end
      end
      ready_prev = (bus.ready_o === 1'b1);
    end
  end

  // Directed cases, abort and reset scenarios, then a randomized sweep.
  initial begin
    int             edges;
    bit             seen;
    bit             any_ready;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic           rs;

    check_count      = 0;
    pass_count       = 0;
    rst              = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;

    #1 rst = 1'b1;
    #2;
    checkOutput("reset_ready", 64'(bus.ready_o), 64'd0);
    checkOutput("reset_result", bus.result_o, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(1'b0, 32'd100, 32'd7, 0);
    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1);
    applyStimulus(1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    applyStimulus(1'b1, 32'd5, 32'd0, 2);
    applyStimulus(1'b0, 32'd5, 32'd0, 0);
    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus(1'b0, 32'd7, 32'd7, 0);

    // Abort after ten iterations; nothing may come out afterwards.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b0;
    checkOutput("annul_ready", 64'(bus.ready_o), 64'd0);
    checkOutput("annul_result", bus.result_o, 64'd0);
    any_ready = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready_o !== 1'b0) any_ready = 1'b1;
    end
    checkOutput("annul_no_ready", 64'(any_ready), 64'd0);
    applyStimulus(1'b0, 32'd9, 32'd4, 0);

    // Asynchronous reset in the middle of an iteration, between edges.
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_divon_ready", 64'(bus.ready_o), 64'd0);
    checkOutput("rst_divon_result", bus.result_o, 64'd0);
    @(negedge clk);
    rst         = 1'b0;
    bus.start_i = 1'b0;
    repeat (40) @(negedge clk);
    applyStimulus(1'b0, 32'd100, 32'd7, 5);

    // Asynchronous reset while a finished result is being presented.
    sb_q.push_back(model(1'b0, 32'd100, 32'd7));
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    waitReady(1'b0, edges, seen);
    checkOutput("rst_divend_latency", 64'(edges), 64'(W + 2));
    if (!seen && sb_q.size() > 0) void'(sb_q.pop_back());
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_divend_ready", 64'(bus.ready_o), 64'd0);
    checkOutput("rst_divend_result", bus.result_o, 64'd0);
    @(negedge clk);
    rst         = 1'b0;
    bus.start_i = 1'b0;
    @(negedge clk);

    // Randomized sweep with a bias towards the interesting divisors.
    for (int i = 0; i < 30; i++) begin
      rs = 1'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        4:       rb = ra;
        default: rb = $urandom;
      endcase
      applyStimulus(rs, ra, rb, $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drain", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
